// File: rtl/prize_pkg.sv
// Shared types and constants for the prize collision detector and prize controller.
package prize_pkg;
   typedef enum logic [1:0] {
      ARMED,
      HOLD,
      WAIT_FRAME
   } prize_det_state_t;

   localparam int unsigned COORD_W    = 11;
   localparam int unsigned TILE_SHIFT = 6;
endpackage

// File: rtl/prize_collision_detector_if.sv
// Scan-side inputs and collision outputs of the prize collision detector.
interface prize_collision_detector_if;
   import prize_pkg::*;

   logic               startOfFrame;
   logic               enable;
   logic [COORD_W-1:0] pixelX;
   logic [COORD_W-1:0] pixelY;
   logic               bumpyDrawingRequest;
   logic               prizeDrawingRequest;
   logic               prize_collision;
   logic [COORD_W-1:0] hit_x;
   logic [COORD_W-1:0] hit_y;
   logic [7:0]         prizes_collected;

   modport master (
      output startOfFrame, enable, pixelX, pixelY,
             bumpyDrawingRequest, prizeDrawingRequest,
      input  prize_collision, hit_x, hit_y, prizes_collected
   );

   modport slave (
      input  startOfFrame, enable, pixelX, pixelY,
             bumpyDrawingRequest, prizeDrawingRequest,
      output prize_collision, hit_x, hit_y, prizes_collected
   );
endinterface

// File: rtl/prize_collision_detector_pulse_gen.sv
// Registered pulse generator: trigger loads the down-counter, pulse lasts len+1 cycles.
module prize_pulse_gen (
   input  logic       clk,
   input  logic       resetN,
   input  logic       trigger,
   input  logic [3:0] len,
   output logic       pulse,
   output logic       done
);
   logic [3:0] cnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         cnt   <= '0;
         pulse <= 1'b0;
      end else if (trigger) begin
         cnt   <= len;
         pulse <= 1'b1;
      end else if (pulse) begin
         if (cnt == '0) pulse <= 1'b0;
         else           cnt   <= cnt - 4'd1;
      end
   end

   // Last high cycle of the pulse.
   assign done = pulse && (cnt == '0);
endmodule

// File: rtl/prize_collision_detector.sv
// Detects the first bumpy/prize overlap per frame and emits one registered collision pulse.
// Optional collected-prize counter enabled by defining PRIZE_SCORE_EN.
module prize_collision_detector
   import prize_pkg::*;
#(
   parameter int unsigned PULSE_LEN = 4,
   parameter int unsigned SAT_MAX   = 255
) (
   input logic                       clk,
   input logic                       resetN,
   prize_collision_detector_if.slave bus
);
   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);

   if (PULSE_LEN < 1 || PULSE_LEN > 15 || SAT_MAX > 255) begin : g_bad_param
      $error("prize_collision_detector: PULSE_LEN must be 1..15 and SAT_MAX <= 255");
   end

   prize_det_state_t state;
   logic             sof_pending;
   logic             overlap;
   logic             trigger;
   logic             pulse;
   logic             done;

   assign overlap = bus.enable & bus.bumpyDrawingRequest & bus.prizeDrawingRequest;
   assign trigger = (state == ARMED) && overlap;

   prize_pulse_gen u_pulse (
      .clk     (clk),
      .resetN  (resetN),
      .trigger (trigger),
      .len     (PULSE_LOAD),
      .pulse   (pulse),
      .done    (done)
   );

   assign bus.prize_collision = pulse;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= ARMED;
         sof_pending <= 1'b0;
         bus.hit_x   <= '0;
         bus.hit_y   <= '0;
      end else begin
         case (state)
            ARMED: begin
               if (overlap) begin
                  bus.hit_x <= bus.pixelX;
                  bus.hit_y <= bus.pixelY;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               // A frame start on the exit cycle itself still re-arms.
               if (done) begin
                  state       <= (sof_pending || bus.startOfFrame) ? ARMED : WAIT_FRAME;
                  sof_pending <= 1'b0;
               end else if (bus.startOfFrame) begin
                  sof_pending <= 1'b1;
               end
            end
            WAIT_FRAME: begin
               if (bus.startOfFrame) state <= ARMED;
            end
            default: state <= ARMED;
         endcase
      end
   end

`ifdef PRIZE_SCORE_EN
   localparam logic [7:0] SAT_VAL = 8'(SAT_MAX);
   logic [7:0] collected;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                           collected <= '0;
      else if (trigger && collected < SAT_VAL) collected <= collected + 8'd1;
   end

   assign bus.prizes_collected = collected;
`else
   assign bus.prizes_collected = '0;
`endif
endmodule

// File: tb/tb_prize_collision_detector.sv
// Randomized bench for prize_collision_detector against a frame-level reference model.
module tb_prize_collision_detector;
   import prize_pkg::*;

   localparam int unsigned PL  = 4;
   localparam int unsigned SAT = 3;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   prize_collision_detector_if bus ();

   prize_collision_detector #(
      .PULSE_LEN (PL),
      .SAT_MAX   (SAT)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference: pulse cycles still owed, whether this frame may still score,
   // whether a new frame began while the pulse was running.
   int unsigned m_rem;
   bit          m_armed;
   bit          m_new_frame;
   int unsigned m_hx, m_hy, m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rem = 0; m_armed = 1'b1; m_new_frame = 1'b0;
      m_hx = 0; m_hy = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input bit sof, input bit ovl, input int unsigned x, input int unsigned y);
      if (m_rem > 0) begin
         m_new_frame = m_new_frame | sof;
         if (m_rem == 1) begin
            m_armed     = m_new_frame;
            m_new_frame = 1'b0;
         end
         m_rem--;
      end else if (m_armed) begin
         if (ovl) begin
            m_rem   = PL;
            m_hx    = x;
            m_hy    = y;
            m_armed = 1'b0;
            if (m_cnt < SAT) m_cnt++;
         end
      end else if (sof) begin
         m_armed = 1'b1;
      end
   endtask

   task automatic check_all();
      check("prize_collision", 32'(bus.prize_collision), 32'(m_rem > 0));
      check("hit_x", 32'(bus.hit_x), m_hx);
      check("hit_y", 32'(bus.hit_y), m_hy);
`ifdef PRIZE_SCORE_EN
      check("prizes_collected", 32'(bus.prizes_collected), m_cnt);
`else
      check("prizes_collected", 32'(bus.prizes_collected), 32'd0);
`endif
   endtask

   task automatic drive(input bit sof, input bit en, input bit b, input bit p,
                        input int unsigned x, input int unsigned y);
      bus.startOfFrame        = sof;
      bus.enable              = en;
      bus.bumpyDrawingRequest = b;
      bus.prizeDrawingRequest = p;
      bus.pixelX              = COORD_W'(x);
      bus.pixelY              = COORD_W'(y);
   endtask

   task automatic step(input bit sof, input bit en, input bit b, input bit p,
                       input int unsigned x, input int unsigned y);
      drive(sof, en, b, p, x, y);
      @(posedge clk);
      model_edge(sof, en & b & p, x % 2048, y % 2048);
      #1;
      check_all();
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step(0, 1, 0, 0, 10 + i, 20);
   endtask

   int unsigned exp_score[5] = '{1, 2, 3, 3, 3};

   initial begin
      resetN = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all();
      resetN = 1'b1;

      // First overlap of the frame, then a second one that must be ignored.
      step(0, 1, 1, 1, 130, 70);
      check("hit_x_first", 32'(bus.hit_x), 32'd130);
      check("hit_y_first", 32'(bus.hit_y), 32'd70);
      idle(5);
      step(0, 1, 1, 1, 140, 70);
      check("no_pulse_same_frame", 32'(bus.prize_collision), 32'd0);
      check("hit_x_kept", 32'(bus.hit_x), 32'd130);
      idle(2);

      // New frame, new pulse.
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 200, 300);
      check("hit_x_second", 32'(bus.hit_x), 32'd200);
      check("hit_y_second", 32'(bus.hit_y), 32'd300);

      // Frame start during the pulse re-arms immediately after it.
      step(1, 1, 0, 0, 0, 0);
      idle(3);
      check("pulse_ended", 32'(bus.prize_collision), 32'd0);
      step(0, 1, 1, 1, 55, 66);
      check("rearm_pulse", 32'(bus.prize_collision), 32'd1);
      check("rearm_hit_x", 32'(bus.hit_x), 32'd55);
      idle(5);

      // Reset on the second cycle of a pulse.
      step(1, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 300, 400);
      step(0, 1, 0, 0, 0, 0);
      check("pulse_before_reset", 32'(bus.prize_collision), 32'd1);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1 resetN = 1'b1;
      step(0, 1, 1, 1, 7, 9);
      check("armed_after_reset", 32'(bus.prize_collision), 32'd1);
      idle(5);

      // Score saturation over five frames.
      resetN = 1'b0;
      #1;
      model_reset();
      #2 resetN = 1'b1;
      for (int unsigned f = 0; f < 5; f++) begin
         step(1, 1, 0, 0, 0, 0);
         step(0, 1, 1, 1, 100 + f, 50);
         idle(5);
`ifdef PRIZE_SCORE_EN
         check("score_frame", 32'(bus.prizes_collected), exp_score[f]);
`else
         check("score_frame", 32'(bus.prizes_collected), 32'd0);
`endif
      end

      // Randomized scan traffic.
      for (int unsigned i = 0; i < 3000; i++) begin
         step($urandom_range(0, 11) == 0, $urandom_range(0, 7) != 0,
              1'($urandom), 1'($urandom),
              $urandom_range(0, 2047), $urandom_range(0, 2047));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
